conv_maxpool: RTL and testbench

Streaming 2x2, stride-2 max-pooling stage placed directly downstream of the convolver. It consumes the convolver's raster-order output stream (`conv_op` qualified by `valid_conv`) for an m x m feature map. It applies optional ReLU and emits a floor(m/2) x floor(m/2) pooled map in raster order. One line buffer of floor(m/2) partial maxima holds the state between the two rows of each pooling window.

---
 rtl/conv_maxpool.sv | 143 ++++++++++++++
 tb/tb_conv_maxpool.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_maxpool.sv
// conv_maxpool: streaming 2x2 / stride-2 max pooling of the convolver's
// raster-order output. It applies optional ReLU, pairs horizontally through a
// hold register, and pairs vertically through a line buffer of
// floor(M/2) partial maxima. Pooled samples come out in raster order.
module conv_maxpool #(
  parameter int M    = 8,   // feature-map width and height, >= 2
  parameter int N    = 16,  // signed sample width
  parameter int Q    = 12,  // fractional bits; max() is scale-independent
  parameter int RELU = 1    // 1: clamp negatives to zero before pooling
) (
  input  logic         clk,
  input  logic         global_rst_n,
  input  logic         ce,
  input  logic [N-1:0] conv_in,
  input  logic         valid_in,
  output logic [N-1:0] pool_op,
  output logic         valid_op,
  output logic         end_op
);

  // Pooled map size and the extent of the even-aligned window region.
  localparam int P   = M / 2;
  localparam int WIN = 2 * P;
  localparam int CW  = (M > 1) ? $clog2(M) : 1;
  localparam int LW  = (P > 1) ? $clog2(P) : 1;

  localparam logic [CW-1:0] LAST_IDX = CW'(M - 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(WIN - 1);

  // Reject configurations the datapath cannot represent.
  if (M < 2 || Q >= N) begin : g_cfg_check
    $error("conv_maxpool: need M >= 2 and Q < N");
  end

  // Signed maximum; on a tie either operand is the same value.
  function automatic logic signed [N-1:0] smax(input logic signed [N-1:0] a,
                                               input logic signed [N-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0]         col_q, col_d;
  logic [CW-1:0]         row_q, row_d;
  logic signed [N-1:0]   h_q, h_d;
  logic signed [N-1:0]   pool_q, pool_d;
  logic                  valid_q, valid_d;
  logic                  end_q, end_d;
  logic signed [N-1:0]   lbuf_q [P];

  // ---------------------------------------------------------------------------
  // Datapath terms
  // ---------------------------------------------------------------------------
  logic                  accept;
  logic                  in_window;
  logic signed [N-1:0]   x;
  logic signed [N-1:0]   pair;
  logic signed [N-1:0]   lbuf_rd;
  logic [LW-1:0]         lidx;
  logic                  lbuf_we;

  assign accept    = ce && valid_in;
  // Trailing column/row of an odd-sized map never forms a complete window.
  assign in_window = (int'(col_q) < WIN) && (int'(row_q) < WIN);
  assign x         = ((RELU != 0) && conv_in[N-1]) ? '0 : $signed(conv_in);
  assign pair      = smax(h_q, x);
  // Window column index: one line-buffer slot per pooled output column.
  assign lidx      = LW'(col_q >> 1);
  assign lbuf_rd   = lbuf_q[lidx];

  // Next-state logic for counters, hold register, pooled output and pulses.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    col_d   = col_q;
    row_d   = row_q;
    h_d     = h_q;
    pool_d  = pool_q;
    valid_d = 1'b0;
    end_d   = 1'b0;
    lbuf_we = 1'b0;

    if (accept) begin
      if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = (row_q == LAST_IDX) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      if (in_window) begin
        if (!col_q[0]) begin
          h_d = x;
        end else if (!row_q[0]) begin
          lbuf_we = 1'b1;
        end else begin
          pool_d  = smax(lbuf_rd, pair);
          valid_d = 1'b1;
          end_d   = (col_q == WIN_LAST) && (row_q == WIN_LAST);
        end
      end
    end
  end

  // Control and output registers; pulses drop on any edge without an output.
  always_ff @(posedge clk or negedge global_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!global_rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      h_q     <= '0;
      pool_q  <= '0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      h_q     <= h_d;
      pool_q  <= pool_d;
      valid_q <= valid_d;
      end_q   <= end_d;
    end
  end

  // Line buffer of even-row pair maxima, one entry per pooled column.
  always_ff @(posedge clk or negedge global_rst_n) begin
    // NOTE: the buffer is small and register-based, so it is reset to a known
    // zero state; it is never cleared between frames because each entry is
    // rewritten in an even row before the odd row reads it.
    if (!global_rst_n) begin
      for (int i = 0; i < P; i++) begin
        lbuf_q[i] <= '0;
      end
    end else if (lbuf_we) begin
      lbuf_q[lidx] <= pair;
    end
  end

  assign pool_op  = pool_q;
  assign valid_op = valid_q;
  assign end_op   = end_q;

endmodule

// File: tb/tb_conv_maxpool.sv
// Bench for conv_maxpool. Three instances (M=4 RELU=0, M=4 RELU=1,
// M=5 RELU=0) share clock, reset, ce and data; each has its own valid_in.
// A 2-D frame model predicts every pooled sample when its last input is
// driven; a per-instance monitor pops and compares data, end flag and cycle.
module tb_conv_maxpool;

  localparam int ND = 3;

  typedef struct {
    logic signed [15:0] data;
    bit                 last;
    int                 cyc;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic               ce;
  logic [15:0]        din;
  logic [ND-1:0]      vin;
  logic [15:0]        pool [ND];
  logic [ND-1:0]      vop;
  logic [ND-1:0]      eop;

  int pass_cnt;
  int total_cnt;
  int cyc;
  int vld_cnt [ND];
  int end_cnt [ND];

  // Model configuration and state.
  int                 mdl_m    [ND] = '{4, 4, 5};
  int                 mdl_relu [ND] = '{0, 1, 0};
  int                 pos_r    [ND];
  int                 pos_c    [ND];
  logic signed [15:0] fr       [ND][5][5];
  exp_t               sb       [ND][$];

  conv_maxpool #(.M(4), .N(16), .Q(12), .RELU(0)) u_m4 (
    .clk(clk), .global_rst_n(rst_n), .ce(ce), .conv_in(din), .valid_in(vin[0]),
    .pool_op(pool[0]), .valid_op(vop[0]), .end_op(eop[0]));

  conv_maxpool #(.M(4), .N(16), .Q(12), .RELU(1)) u_m4_relu (
    .clk(clk), .global_rst_n(rst_n), .ce(ce), .conv_in(din), .valid_in(vin[1]),
    .pool_op(pool[1]), .valid_op(vop[1]), .end_op(eop[1]));

  conv_maxpool #(.M(5), .N(16), .Q(12), .RELU(0)) u_m5 (
    .clk(clk), .global_rst_n(rst_n), .ce(ce), .conv_in(din), .valid_in(vin[2]),
    .pool_op(pool[2]), .valid_op(vop[2]), .end_op(eop[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic signed [15:0] smax(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    return (a > b) ? a : b;
  endfunction

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < ND; k++) begin
      if (vop[k]) begin
        exp_t e;
        vld_cnt[k]++;
        if (sb[k].size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_valid dut%0d: got pool_op=%0d with no output expected (cycle %0d)",
                   k, $signed(pool[k]), cyc);
        end else begin
          e = sb[k].pop_front();
          total_cnt++;
          if ($signed(pool[k]) !== e.data)
            $display("FAIL pool_op dut%0d: got %0d, expected %0d", k, $signed(pool[k]), e.data);
          else pass_cnt++;
          total_cnt++;
          if (eop[k] !== e.last)
            $display("FAIL end_op dut%0d: got %0b, expected %0b", k, eop[k], e.last);
          else pass_cnt++;
          total_cnt++;
          if (cyc !== e.cyc)
            $display("FAIL latency dut%0d: valid_op after edge %0d, expected after edge %0d", k, cyc, e.cyc);
          else pass_cnt++;
        end
      end
      if (eop[k]) begin
        end_cnt[k]++;
        if (!vop[k]) begin
          total_cnt++;
          $display("FAIL end_without_valid dut%0d: end_op=1 while valid_op=0", k);
        end
      end
    end
  end

  // One accepted sample to every instance selected in mask, optionally
  // preceded by random non-accepting cycles (ce low or valid_in low).
  task automatic drive(input int mask, input logic signed [15:0] v, input bit gaps);
    if (gaps) begin
      while ($urandom_range(1, 0) == 1) begin
        ce  = $urandom_range(1, 0) == 1;
        vin = ce ? '0 : ND'(mask);
        din = 16'($urandom);
        @(posedge clk); #1;
      end
    end
    ce  = 1'b1;
    vin = ND'(mask);
    din = v;
    for (int k = 0; k < ND; k++) begin
      if (mask[k]) begin
        int r, c, w;
        logic signed [15:0] xv;
        r  = pos_r[k];
        c  = pos_c[k];
        w  = 2 * (mdl_m[k] / 2);
        xv = (mdl_relu[k] != 0 && v < 0) ? 16'sd0 : v;
        fr[k][r][c] = xv;
        if (r < w && c < w && (r % 2) == 1 && (c % 2) == 1) begin
          exp_t e;
          e.data = smax(smax(fr[k][r-1][c-1], fr[k][r-1][c]), smax(fr[k][r][c-1], xv));
          e.last = (r == w - 1) && (c == w - 1);
          e.cyc  = cyc + 1;
          sb[k].push_back(e);
        end
        if (c == mdl_m[k] - 1) begin
          pos_c[k] = 0;
          pos_r[k] = (r == mdl_m[k] - 1) ? 0 : r + 1;
        end else begin
          pos_c[k] = c + 1;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    ce  = 1'b0;
    vin = '0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_reset();
    ce    = 1'b0;
    vin   = '0;
    rst_n = 1'b0;
    for (int k = 0; k < ND; k++) begin
      pos_r[k] = 0;
      pos_c[k] = 0;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    ce    = 1'b0;
    vin   = '0;
    din   = '0;
    rst_n = 1'b0;
    #12;
    for (int k = 0; k < ND; k++) begin
      total_cnt++;
      if (pool[k] !== 16'd0) $display("FAIL reset_pool_op dut%0d: got %0d, expected 0", k, pool[k]);
      else pass_cnt++;
      total_cnt++;
      if (vop[k] !== 1'b0) $display("FAIL reset_valid_op dut%0d: got %0b, expected 0", k, vop[k]);
      else pass_cnt++;
      total_cnt++;
      if (eop[k] !== 1'b0) $display("FAIL reset_end_op dut%0d: got %0b, expected 0", k, eop[k]);
      else pass_cnt++;
    end
    apply_reset();
  endtask

  task automatic test_ramp();
    int v0, e0;
    v0 = vld_cnt[0];
    e0 = end_cnt[0];
    for (int i = 0; i < 16; i++) drive(1, 16'(i), 1'b0);
    idle(3);
    total_cnt++;
    if (vld_cnt[0] - v0 !== 4) $display("FAIL ramp_valid_count: got %0d, expected 4", vld_cnt[0] - v0);
    else pass_cnt++;
    total_cnt++;
    if (end_cnt[0] - e0 !== 1) $display("FAIL ramp_end_count: got %0d, expected 1", end_cnt[0] - e0);
    else pass_cnt++;
  endtask

  task automatic test_relu();
    int v1;
    v1 = vld_cnt[1];
    for (int i = 0; i < 16; i++) drive(3, (i == 6) ? 16'sd300 : -16'sd256, 1'b0);
    idle(3);
    total_cnt++;
    if (vld_cnt[1] - v1 !== 4) $display("FAIL relu_valid_count: got %0d, expected 4", vld_cnt[1] - v1);
    else pass_cnt++;
  endtask

  task automatic test_gaps();
    int v0, e0;
    v0 = vld_cnt[0];
    e0 = end_cnt[0];
    for (int i = 0; i < 16; i++) drive(1, 16'(i), 1'b1);
    idle(3);
    total_cnt++;
    if (vld_cnt[0] - v0 !== 4) $display("FAIL gaps_valid_count: got %0d, expected 4", vld_cnt[0] - v0);
    else pass_cnt++;
    total_cnt++;
    if (end_cnt[0] - e0 !== 1) $display("FAIL gaps_end_count: got %0d, expected 1", end_cnt[0] - e0);
    else pass_cnt++;
  endtask

  task automatic test_odd_size();
    int v2, e2;
    v2 = vld_cnt[2];
    e2 = end_cnt[2];
    for (int i = 0; i < 25; i++) drive(4, 16'(i), 1'b0);
    idle(3);
    total_cnt++;
    if (vld_cnt[2] - v2 !== 4) $display("FAIL odd_valid_count: got %0d, expected 4", vld_cnt[2] - v2);
    else pass_cnt++;
    total_cnt++;
    if (end_cnt[2] - e2 !== 1) $display("FAIL odd_end_count: got %0d, expected 1", end_cnt[2] - e2);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    for (int i = 0; i < 10; i++) drive(1, 16'(i), 1'b0);
    apply_reset();
    v0 = vld_cnt[0];
    for (int i = 0; i < 16; i++) drive(1, 16'(100 + i), 1'b0);
    idle(3);
    total_cnt++;
    if (vld_cnt[0] - v0 !== 4) $display("FAIL reset_mid_valid_count: got %0d, expected 4", vld_cnt[0] - v0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int v0, e0;
    v0 = vld_cnt[0];
    e0 = end_cnt[0];
    for (int i = 0; i < 16; i++) drive(1, 16'(i), 1'b0);
    for (int i = 0; i < 16; i++) drive(1, 16'(15 - i), 1'b0);
    idle(3);
    total_cnt++;
    if (vld_cnt[0] - v0 !== 8) $display("FAIL b2b_valid_count: got %0d, expected 8", vld_cnt[0] - v0);
    else pass_cnt++;
    total_cnt++;
    if (end_cnt[0] - e0 !== 2) $display("FAIL b2b_end_count: got %0d, expected 2", end_cnt[0] - e0);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    cyc       = 0;
    for (int k = 0; k < ND; k++) begin
      vld_cnt[k] = 0;
      end_cnt[k] = 0;
      pos_r[k]   = 0;
      pos_c[k]   = 0;
    end
    test_reset();
    test_ramp();
    test_relu();
    test_gaps();
    test_odd_size();
    test_reset_mid_frame();
    test_back_to_back();
    idle(4);
    for (int k = 0; k < ND; k++) begin
      total_cnt++;
      if (sb[k].size() !== 0) $display("FAIL missing_outputs dut%0d: %0d expected outputs never seen", k, sb[k].size());
      else pass_cnt++;
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
